// File: rtl/snn_step_sequencer.sv
// Autonomous timestep controller for snn_core: fetches events, captures spikes,
// runs optional STDP scans and dumps learned weights over valid/ready streams.
module snn_step_sequencer #(
    parameter int unsigned F        = 48,
    parameter int unsigned N        = 96,
    parameter int unsigned AW       = $clog2(F*N),
    parameter int unsigned EAW      = 16,
    parameter int unsigned TW       = 16,
    parameter int unsigned CORE_LAT = 1
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           start,
    input  logic [TW-1:0]  num_steps,
    input  logic           learn_en,
    output logic           busy,
    output logic           done,
    output logic [EAW-1:0] ev_addr,
    input  logic [F-1:0]   ev_rdata,
    output logic [F-1:0]   event_vec,
    input  logic [N-1:0]   spikes_vec,
    output logic           stdp_enable,
    output logic [F-1:0]   stdp_pre_bits,
    output logic [N-1:0]   stdp_post_bits,
    output logic [AW-1:0]  rb_addr,
    input  logic [15:0]    rb_data,
    output logic           spk_valid,
    input  logic           spk_ready,
    output logic [N-1:0]   spk_data,
    output logic [TW-1:0]  spk_step,
    output logic           w_valid,
    input  logic           w_ready,
    output logic [15:0]    w_data,
    output logic [AW-1:0]  w_addr
);

    localparam int unsigned   LW       = (CORE_LAT < 1) ? 1 : $clog2(CORE_LAT + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(F*N - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_EVAL,
        S_EMIT,
        S_LEARN,
        S_GAP,
        S_NEXT,
        S_DUMP_RD,
        S_DUMP_CAP,
        S_DUMP_W,
        S_DONE
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] t;
    logic [TW-1:0] t_last;
    logic          learn;
    logic [LW-1:0] lat_cnt;
    logic [AW-1:0] scan_cnt;
    logic [AW-1:0] dump_addr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n     = state;
        busy        = (state != S_IDLE);
        done        = (state == S_DONE);
        spk_valid   = (state == S_EMIT);
        stdp_enable = (state == S_LEARN);
        w_valid     = (state == S_DUMP_W);
        case (state)
            S_IDLE:     if (start) state_n = (num_steps == '0) ? S_DONE : S_FETCH;
            S_FETCH:    state_n = S_LOAD;
            S_LOAD:     state_n = S_EVAL;
            S_EVAL:     if (lat_cnt == '0) state_n = S_EMIT;
            S_EMIT:     if (spk_ready) state_n = learn ? S_LEARN : S_NEXT;
            S_LEARN:    if (scan_cnt == LAST_IDX) state_n = S_GAP;
            S_GAP:      state_n = S_NEXT;
            S_NEXT: begin
                if (t != t_last) state_n = S_FETCH;
                else             state_n = learn ? S_DUMP_RD : S_DONE;
            end
            S_DUMP_RD:  state_n = S_DUMP_CAP;
            S_DUMP_CAP: state_n = S_DUMP_W;
            S_DUMP_W:   if (w_ready) state_n = (dump_addr == LAST_IDX) ? S_DONE : S_DUMP_RD;
            S_DONE:     state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            t         <= '0;
            t_last    <= '0;
            learn     <= 1'b0;
            event_vec <= '0;
            lat_cnt   <= '0;
            spk_data  <= '0;
            spk_step  <= '0;
            scan_cnt  <= '0;
            dump_addr <= '0;
            w_data    <= '0;
            w_addr    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && (num_steps != '0)) begin
                        t      <= '0;
                        t_last <= num_steps - 1'b1;
                        learn  <= learn_en;
                    end
                end
                S_LOAD: begin
                    event_vec <= ev_rdata;
                    lat_cnt   <= LW'(CORE_LAT);
                end
                // Capture one cycle after the counter expires so a registered core has settled.
                S_EVAL: begin
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end else begin
                        spk_data <= spikes_vec;
                        spk_step <= t;
                    end
                end
                S_EMIT: if (spk_ready) scan_cnt <= '0;
                S_LEARN: scan_cnt <= scan_cnt + 1'b1;
                S_NEXT: begin
                    if (t != t_last) begin
                        t <= t + 1'b1;
                    end else begin
                        event_vec <= '0;
                        dump_addr <= '0;
                    end
                end
                S_DUMP_CAP: begin
                    w_data <= rb_data;
                    w_addr <= dump_addr;
                end
                S_DUMP_W: if (w_ready && (dump_addr != LAST_IDX)) dump_addr <= dump_addr + 1'b1;
                default: ;
            endcase
        end
    end

    assign stdp_pre_bits  = stdp_enable ? event_vec : '0;
    assign stdp_post_bits = stdp_enable ? spk_data : '0;
    assign rb_addr        = dump_addr;

    generate
        if (TW >= EAW) begin : g_addr_trunc
            assign ev_addr = t[EAW-1:0];
        end else begin : g_addr_ext
            assign ev_addr = {{(EAW-TW){1'b0}}, t};
        end
    endgenerate

endmodule

// File: tb/tb_snn_step_sequencer.sv
// Scoreboard bench for snn_step_sequencer with a small registered snn_core stand-in.
module tb_snn_step_sequencer;

    localparam int F    = 48;
    localparam int N    = 96;
    localparam int AW   = $clog2(F*N);
    localparam int EAW  = 16;
    localparam int TW   = 16;
    localparam int SCAN = F*N;

    logic           clk = 1'b0;
    logic           rstn = 1'b1;
    logic           start = 1'b0;
    logic [TW-1:0]  num_steps = '0;
    logic           learn_en = 1'b0;
    logic           busy, done;
    logic [EAW-1:0] ev_addr;
    logic [F-1:0]   ev_rdata = '0;
    logic [F-1:0]   event_vec;
    logic [N-1:0]   spikes_vec = '0;
    logic           stdp_enable;
    logic [F-1:0]   stdp_pre_bits;
    logic [N-1:0]   stdp_post_bits;
    logic [AW-1:0]  rb_addr;
    logic [15:0]    rb_data = '0;
    logic           spk_valid;
    logic           spk_ready = 1'b1;
    logic [N-1:0]   spk_data;
    logic [TW-1:0]  spk_step;
    logic           w_valid;
    logic           w_ready = 1'b1;
    logic [15:0]    w_data;
    logic [AW-1:0]  w_addr;

    snn_step_sequencer #(
        .F(F), .N(N), .AW(AW), .EAW(EAW), .TW(TW), .CORE_LAT(1)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .num_steps(num_steps), .learn_en(learn_en),
        .busy(busy), .done(done), .ev_addr(ev_addr), .ev_rdata(ev_rdata), .event_vec(event_vec),
        .spikes_vec(spikes_vec), .stdp_enable(stdp_enable), .stdp_pre_bits(stdp_pre_bits),
        .stdp_post_bits(stdp_post_bits), .rb_addr(rb_addr), .rb_data(rb_data),
        .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_data(spk_data), .spk_step(spk_step),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_addr(w_addr)
    );

    always #5 clk = ~clk;

    logic [F-1:0] mem [0:7];

    function automatic logic [N-1:0] spk_fn(input logic [F-1:0] e);
        return {e ^ 48'h0F0F_3C3C_A5A5, ~e};
    endfunction

    function automatic logic [15:0] wgt_fn(input logic [AW-1:0] a);
        logic [31:0] p;
        p = 32'(a) * 32'd37;
        return p[15:0] ^ 16'h5A5A;
    endfunction

    // snn_core and event memory stand-ins, all with one cycle of read latency
    always @(posedge clk) begin
        ev_rdata   <= mem[ev_addr[2:0]];
        spikes_vec <= spk_fn(event_vec);
        rb_data    <= wgt_fn(rb_addr);
    end

    typedef struct packed { logic [TW-1:0] step; logic [N-1:0] data; } spk_exp_t;
    typedef struct packed { logic [AW-1:0] addr; logic [15:0] data; } w_exp_t;
    typedef struct packed { logic [F-1:0] pre; logic [N-1:0] post; } scan_exp_t;

    spk_exp_t  spk_q[$];
    w_exp_t    w_q[$];
    scan_exp_t scan_q[$];

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic push_run(input int ns, input bit le);
        for (int s = 0; s < ns; s++) begin
            spk_q.push_back('{step: TW'(s), data: spk_fn(mem[s[2:0]])});
            if (le) scan_q.push_back('{pre: mem[s[2:0]], post: spk_fn(mem[s[2:0]])});
        end
        if (le)
            for (int a = 0; a < SCAN; a++) w_q.push_back('{addr: AW'(a), data: wgt_fn(AW'(a))});
    endtask

    int           busy_cycles = 0;
    int           done_cnt = 0;
    bit           in_scan = 0;
    int           scan_len = 0;
    int           scan_bad = 0;
    logic [F-1:0] scan_pre;
    logic [N-1:0] scan_post;
    bit           hold_w = 0;
    logic [15:0]  held_d;
    logic [AW-1:0] held_a;

    always @(negedge clk) begin
        spk_exp_t  se;
        w_exp_t    we;
        scan_exp_t ce;
        if (!rstn) begin
            in_scan  = 0;
            scan_len = 0;
            scan_bad = 0;
            hold_w   = 0;
        end else begin
            if (busy) busy_cycles++;
            if (done) done_cnt++;
            if (spk_valid && spk_ready) begin
                check("spk_expected", 128'(spk_q.size() > 0), 128'(1));
                if (spk_q.size() > 0) begin
                    se = spk_q.pop_front();
                    check("spk_step", 128'(spk_step), 128'(se.step));
                    check("spk_data", 128'(spk_data), 128'(se.data));
                    check("ev_addr_at_emit", 128'(ev_addr), 128'(se.step));
                end
            end
            if (w_valid) begin
                if (hold_w) begin
                    check("w_stall_data", 128'(w_data), 128'(held_d));
                    check("w_stall_addr", 128'(w_addr), 128'(held_a));
                end
                if (w_ready) begin
                    hold_w = 0;
                    check("w_expected", 128'(w_q.size() > 0), 128'(1));
                    if (w_q.size() > 0) begin
                        we = w_q.pop_front();
                        check("w_addr", 128'(w_addr), 128'(we.addr));
                        check("w_data", 128'(w_data), 128'(we.data));
                    end
                end else begin
                    hold_w = 1;
                    held_d = w_data;
                    held_a = w_addr;
                end
            end else begin
                if (hold_w) check("w_valid_dropped", 128'(w_valid), 128'(1));
                hold_w = 0;
            end
            if (stdp_enable) begin
                if (!in_scan) begin
                    in_scan   = 1;
                    scan_len  = 0;
                    scan_bad  = 0;
                    scan_pre  = stdp_pre_bits;
                    scan_post = stdp_post_bits;
                end else if (stdp_pre_bits !== scan_pre || stdp_post_bits !== scan_post) begin
                    scan_bad++;
                end
                scan_len++;
            end else if (in_scan) begin
                in_scan = 0;
                check("scan_expected", 128'(scan_q.size() > 0), 128'(1));
                if (scan_q.size() > 0) begin
                    ce = scan_q.pop_front();
                    check("scan_len", 128'(scan_len), 128'(SCAN));
                    check("scan_pre", 128'(scan_pre), 128'(ce.pre));
                    check("scan_post", 128'(scan_post), 128'(ce.post));
                    check("scan_stable", 128'(scan_bad), 128'(0));
                end
            end
        end
    end

    task automatic run(input int ns, input bit le, input int limit);
        bit got;
        busy_cycles = 0;
        done_cnt    = 0;
        @(posedge clk); #1;
        start = 1'b1; num_steps = TW'(ns); learn_en = le;
        @(posedge clk); #1;
        start = 1'b0;
        got = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done) begin got = 1; break; end
        end
        check("done_seen", 128'(got), 128'(1));
        repeat (4) @(posedge clk);
        #1;
        check("done_once", 128'(done_cnt), 128'(1));
        check("spk_q_drained", 128'(spk_q.size()), 128'(0));
        check("w_q_drained", 128'(w_q.size()), 128'(0));
        check("scan_q_drained", 128'(scan_q.size()), 128'(0));
        check("event_vec_cleared", 128'(event_vec), 128'(0));
        check("busy_after_run", 128'(busy), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0]   sd;
        logic [TW-1:0]  ss;
        logic [EAW-1:0] ea;
        bit             found;
        bit             stop_rand;
        int             k;

        mem[0] = 48'h1234_5678_9ABC; mem[1] = 48'hFEDC_BA98_7654;
        mem[2] = 48'h0000_FFFF_0001; mem[3] = 48'h8000_0000_0001;
        mem[4] = 48'hAAAA_5555_AAAA; mem[5] = 48'h0F0F_0F0F_0F0F;
        mem[6] = 48'hC3C3_C3C3_C3C3; mem[7] = 48'h7FFF_FFFF_FFFE;

        #3 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_spk_valid", 128'(spk_valid), 128'(0));
        check("rst_w_valid", 128'(w_valid), 128'(0));
        check("rst_stdp", 128'(stdp_enable), 128'(0));
        check("rst_event_vec", 128'(event_vec), 128'(0));
        check("rst_ev_addr", 128'(ev_addr), 128'(0));
        rstn = 1'b1;

        // three steps, no learning
        push_run(3, 0);
        run(3, 0, 200);
        check("ev_addr_last", 128'(ev_addr), 128'(2));

        // one learning step, weight dump with w_ready tied high
        push_run(1, 1);
        run(1, 1, 30000);

        // spk_ready stall on step 1, plus a start pulse while busy
        push_run(3, 0);
        fork
            run(3, 0, 400);
            begin
                found = 0;
                for (int i = 0; i < 200; i++) begin
                    @(posedge clk); #1;
                    if (spk_valid && spk_step == 1) begin found = 1; break; end
                end
                check("stall_reached", 128'(found), 128'(1));
                if (found) begin
                    sd = spk_data; ss = spk_step; ea = ev_addr;
                    spk_ready = 1'b0;
                    repeat (10) begin
                        @(posedge clk); #1;
                        check("stall_valid", 128'(spk_valid), 128'(1));
                        check("stall_data", 128'(spk_data), 128'(sd));
                        check("stall_step", 128'(spk_step), 128'(ss));
                        check("stall_ev_addr", 128'(ev_addr), 128'(ea));
                        check("stall_stdp", 128'(stdp_enable), 128'(0));
                    end
                    spk_ready = 1'b1;
                    @(posedge clk); #1;
                    start = 1'b1; num_steps = TW'(5);
                    @(posedge clk); #1;
                    start = 1'b0;
                end
            end
        join

        // zero steps: single busy cycle, no event fetch
        ea = ev_addr;
        run(0, 0, 20);
        check("zero_busy_cycles", 128'(busy_cycles), 128'(1));
        check("zero_ev_addr", 128'(ev_addr), 128'(ea));

        // async reset in the middle of an STDP scan
        push_run(2, 1);
        @(posedge clk); #1;
        start = 1'b1; num_steps = TW'(2); learn_en = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (stdp_enable) k++;
            if (k == 2000) break;
        end
        check("learn_reached_2000", 128'(k), 128'(2000));
        rstn = 1'b0;
        #1;
        check("abort_stdp", 128'(stdp_enable), 128'(0));
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_event_vec", 128'(event_vec), 128'(0));
        check("abort_spk_valid", 128'(spk_valid), 128'(0));
        spk_q.delete(); w_q.delete(); scan_q.delete();
        @(posedge clk); #1;
        rstn = 1'b1;
        push_run(3, 0);
        run(3, 0, 200);

        // two learning steps with w_ready toggling randomly
        push_run(2, 1);
        stop_rand = 0;
        fork
            begin
                run(2, 1, 70000);
                stop_rand = 1;
            end
            while (!stop_rand) begin
                @(posedge clk); #1;
                if (!stop_rand) w_ready = 1'($urandom_range(0, 1));
            end
        join
        w_ready = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
